// File: rtl/dlf_nco.sv
// dlf_nco: numerically controlled oscillator fed by the digital loop filter.
// Signed corrections arrive on an AXI-stream slave, are scaled and added to a
// base frequency word, and the resulting FCW steps a phase accumulator once per
// accepted output beat. Truncated phase words leave on an AXI-stream master.
// Optional build macro: DLF_NCO_DITHER_EN adds LFSR dither to the output word.
module dlf_nco #(
    parameter int CTRL_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int GAIN_SHIFT = 8
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic [CTRL_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [ACC_WIDTH-1:0]  base_fcw,
    input  logic                  enable,
    output logic [ACC_WIDTH-1:0]  fcw_out,
    output logic [15:0]           wrap_count
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [ACC_WIDTH-1:0]    acc_reg;
    logic [ACC_WIDTH-1:0]    fcw_reg;
    logic [CTRL_WIDTH-1:0]   corr_reg;
    logic                    sync_pend_reg;
    logic [OUT_WIDTH-1:0]    tdata_reg;
    logic                    tlast_reg;
    logic [15:0]             wrap_count_reg;

    logic                    s_hs;
    logic                    m_hs;
    logic                    load_current;
    logic signed [ACC_WIDTH-1:0] corr_ext;
    logic [ACC_WIDTH-1:0]    corr_scaled;
    logic [ACC_WIDTH:0]      sum_wide;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic                    carry_next;
    logic [OUT_WIDTH-1:0]    word_next;

    // The slave side never back-pressures: the newest correction always wins.
    assign s_axis_tready = resetn;
    assign s_hs          = resetn & s_axis_tvalid;
    assign m_axis_tvalid = (state_reg == RUN);
    assign m_hs          = (state_reg == RUN) & m_axis_tready;

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tlast  = tlast_reg;
    assign fcw_out       = fcw_reg;
    assign wrap_count    = wrap_count_reg;

    // Sign-extend the correction to accumulator width, then apply the loop gain.
    assign corr_ext    = ACC_WIDTH'(signed'(corr_reg));
    assign corr_scaled = corr_ext << GAIN_SHIFT;

    // Next phase: a pending sync request zeroes the phase instead of stepping it.
    always_comb begin
        sum_wide = {1'b0, acc_reg} + {1'b0, fcw_reg};
        acc_next   = sum_wide[ACC_WIDTH-1:0];
        carry_next = sum_wide[ACC_WIDTH];
        if (sync_pend_reg) begin
            acc_next   = '0;
            carry_next = 1'b0;
        end
    end

`ifdef DLF_NCO_DITHER_EN
    // Dither never exceeds one output LSB and is capped at the LFSR width.
    localparam int DITHER_W = ((ACC_WIDTH - OUT_WIDTH) > 16) ? 16 : (ACC_WIDTH - OUT_WIDTH);

    logic [15:0]          lfsr_reg;
    logic [ACC_WIDTH-1:0] dither_ext;
    logic [ACC_WIDTH-1:0] word_src;

    generate
        if (DITHER_W > 0) begin : g_dither
            assign dither_ext = ACC_WIDTH'(lfsr_reg[DITHER_W-1:0]);
        end else begin : g_no_dither
            assign dither_ext = '0;
        end
    endgenerate

    // Dither only touches the emitted word; the accumulator and carry stay clean.
    assign word_src  = acc_next + dither_ext;
    assign word_next = word_src[ACC_WIDTH-1 -: OUT_WIDTH];

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per output handshake.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            lfsr_reg <= 16'hACE1;
        end else if (m_hs) begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
        end
    end
`else
    assign word_next = acc_next[ACC_WIDTH-1 -: OUT_WIDTH];
`endif

    // Next-state logic: start emitting on enable, stop only after a handshake.
    always_comb begin
        state_next   = state_reg;
        load_current = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next   = RUN;
                    load_current = 1'b1;
                end
            end
            RUN: begin
                if (m_axis_tready && !enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Correction capture and FCW update; FCW is refreshed every cycle.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            corr_reg <= '0;
            fcw_reg  <= '0;
        end else begin
            fcw_reg <= base_fcw + corr_scaled;
            if (s_hs) begin
                corr_reg <= s_axis_tdata;
            end
        end
    end

    // Phase-sync request: a new request wins over the clear from a handshake.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            sync_pend_reg <= 1'b0;
        end else if (s_hs && s_axis_tlast) begin
            sync_pend_reg <= 1'b1;
        end else if (m_hs) begin
            sync_pend_reg <= 1'b0;
        end
    end

    // Accumulator and output beat: load current phase on start, step on handshake.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            acc_reg        <= '0;
            tdata_reg      <= '0;
            tlast_reg      <= 1'b0;
            wrap_count_reg <= '0;
        end else if (load_current) begin
            tdata_reg <= acc_reg[ACC_WIDTH-1 -: OUT_WIDTH];
            tlast_reg <= 1'b0;
        end else if (m_hs) begin
            acc_reg   <= acc_next;
            tdata_reg <= word_next;
            tlast_reg <= carry_next;
            if (carry_next) begin
                wrap_count_reg <= wrap_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dlf_nco.sv
// tb_dlf_nco: directed table, hand-written corner sequences and randomized
// traffic checked against a beat-level reference model of the NCO.
module tb_dlf_nco;

    localparam int CW = 16;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int GS = 8;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic [CW-1:0] s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [AW-1:0] base_fcw = '0;
    logic          enable = 1'b0;
    logic [AW-1:0] fcw_out;
    logic [15:0]   wrap_count;

    int checks = 0;
    int failures = 0;

    dlf_nco #(.CTRL_WIDTH(CW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .GAIN_SHIFT(GS)) dut (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .base_fcw(base_fcw), .enable(enable), .fcw_out(fcw_out), .wrap_count(wrap_count)
    );

    always #5 aclk = ~aclk;

    // Reference model: what the oscillator should be emitting, beat by beat.
    logic [AW-1:0] m_acc, m_fcw;
    logic [CW-1:0] m_corr;
    logic [OW-1:0] m_out;
    logic [15:0]   m_wrap, m_lfsr;
    logic          m_last, m_valid, m_sync;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven, then
    // let the DUT take the same edge and return 1 time unit after it.
    task automatic tick();
        logic          hs;
        logic [AW-1:0] new_fcw, nxt, shown;
        longint        sum;
        logic          carry;
        if (!resetn) begin
            m_acc = '0; m_fcw = '0; m_corr = '0; m_out = '0; m_wrap = '0;
            m_last = 1'b0; m_valid = 1'b0; m_sync = 1'b0; m_lfsr = 16'hACE1;
        end else begin
            hs = m_valid && m_axis_tready;
            new_fcw = base_fcw + AW'(longint'($signed(m_corr)) * (longint'(1) << GS));
            if (!m_valid) begin
                if (enable) begin
                    m_valid = 1'b1;
                    m_out   = m_acc[AW-1 -: OW];
                    m_last  = 1'b0;
                end
            end else if (hs) begin
                if (m_sync) begin
                    nxt = '0; carry = 1'b0;
                end else begin
                    sum   = longint'(m_acc) + longint'(m_fcw);
                    nxt   = AW'(sum);
                    carry = (sum >= (longint'(1) << AW));
                end
                m_acc = nxt;
`ifdef DLF_NCO_DITHER_EN
                shown = nxt + AW'(m_lfsr);
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
                shown = nxt;
`endif
                m_out  = shown[AW-1 -: OW];
                m_last = carry;
                if (carry) m_wrap = m_wrap + 16'd1;
                if (!enable) m_valid = 1'b0;
                m_sync = 1'b0;
            end
            m_fcw = new_fcw;
            if (s_axis_tvalid) begin
                m_corr = s_axis_tdata;
                if (s_axis_tlast) m_sync = 1'b1;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        logic        rdy;
        logic [15:0] tdata;
        logic        tlast;
        logic        valid;
        logic [15:0] wrap;
    } vec_t;

    vec_t vecs[23];

    initial begin
        // Directed table: start-up, one full phase revolution, a 5-cycle stall, resume.
        vecs[0] = '{rdy: 1'b0, tdata: 16'h0000, tlast: 1'b0, valid: 1'b1, wrap: 16'd0};
        for (int i = 1; i <= 16; i++) begin
            vecs[i] = '{rdy: 1'b1, tdata: 16'((i * 16'h1000) % 65536),
                        tlast: (i == 16), valid: 1'b1, wrap: ((i == 16) ? 16'd1 : 16'd0)};
        end
        for (int i = 17; i <= 21; i++) begin
            vecs[i] = '{rdy: 1'b0, tdata: 16'h0000, tlast: 1'b1, valid: 1'b1, wrap: 16'd1};
        end
        vecs[22] = '{rdy: 1'b1, tdata: 16'h1000, tlast: 1'b0, valid: 1'b1, wrap: 16'd1};

        // Reset state.
        resetn = 1'b0;
        tick(); tick();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_wrap", 32'(wrap_count), 32'd0);
        chk("rst_fcw", fcw_out, 32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);

        resetn = 1'b1;
        base_fcw = 32'h1000_0000;
        enable = 1'b1;
        chk("s_tready_run", 32'(s_axis_tready), 32'd1);
        for (int i = 0; i < 23; i++) begin
            m_axis_tready = vecs[i].rdy;
            tick();
            $display("vec %0d rdy=%0d tdata=0x%04h tlast=%0d valid=%0d wrap=%0d",
                     i, vecs[i].rdy, m_axis_tdata, m_axis_tlast, m_axis_tvalid, wrap_count);
            chk("vec_tdata", 32'(m_axis_tdata), 32'(vecs[i].tdata));
            chk("vec_tlast", 32'(m_axis_tlast), 32'(vecs[i].tlast));
            chk("vec_tvalid", 32'(m_axis_tvalid), 32'(vecs[i].valid));
            chk("vec_wrap", 32'(wrap_count), 32'(vecs[i].wrap));
        end
        chk("fcw_base", fcw_out, 32'h1000_0000);

        // Positive correction: FCW moves two edges after the s handshake.
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h0100;
        tick();
        s_axis_tvalid = 1'b0;
        chk("corr_pos_edge1", fcw_out, 32'h1000_0000);
        tick();
        chk("corr_pos_edge2", fcw_out, 32'h1001_0000);
        m_axis_tready = 1'b1;
        tick();
        chk("corr_pos_step1", 32'(m_axis_tdata), 32'h2001);
        tick();
        chk("corr_pos_step2", 32'(m_axis_tdata), 32'h3002);

        // Negative correction (-256).
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'hFF00;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        chk("corr_neg_fcw", fcw_out, 32'h0FFF_0000);
        m_axis_tready = 1'b1;
        tick();
        chk("corr_neg_step", 32'(m_axis_tdata), 32'h4001);

        // Phase sync with simultaneous output handshake: applies one beat later.
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = 16'h0000;
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        chk("sync_first_beat", 32'(m_axis_tdata), 32'h5000);
        tick();
        chk("sync_zero_tdata", 32'(m_axis_tdata), 32'h0000);
        chk("sync_zero_tlast", 32'(m_axis_tlast), 32'd0);
        tick();
        chk("sync_resume", 32'(m_axis_tdata), 32'h1000);

        // Disable while stalled: valid holds until the final handshake.
        m_axis_tready = 1'b0; enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dis_stall_valid", 32'(m_axis_tvalid), 32'd1);
            chk("dis_stall_tdata", 32'(m_axis_tdata), 32'h1000);
        end
        m_axis_tready = 1'b1;
        tick();
        chk("dis_final_valid", 32'(m_axis_tvalid), 32'd0);
        tick();
        chk("dis_idle_valid", 32'(m_axis_tvalid), 32'd0);
        enable = 1'b1;
        tick();
        chk("reen_valid", 32'(m_axis_tvalid), 32'd1);
        chk("reen_tdata", 32'(m_axis_tdata), 32'h2000);
        tick();
        chk("reen_step", 32'(m_axis_tdata), 32'h3000);

        // Reset in the middle of a stall.
        m_axis_tready = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        chk("rst_stall_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_stall_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_stall_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_stall_wrap", 32'(wrap_count), 32'd0);
        chk("rst_stall_s_tready", 32'(s_axis_tready), 32'd0);
        resetn = 1'b1;

        // Randomized traffic against the model.
        base_fcw = $urandom;
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            s_axis_tvalid = ($urandom_range(0, 3) == 0);
            s_axis_tdata  = 16'($urandom);
            s_axis_tlast  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) base_fcw = $urandom;
            tick();
            chk("rnd_tvalid", 32'(m_axis_tvalid), 32'(m_valid));
            chk("rnd_tdata", 32'(m_axis_tdata), 32'(m_out));
            chk("rnd_tlast", 32'(m_axis_tlast), 32'(m_last));
            chk("rnd_wrap", 32'(wrap_count), 32'(m_wrap));
            chk("rnd_fcw", fcw_out, m_fcw);
            chk("rnd_s_tready", 32'(s_axis_tready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlf_nco.md
Name: dlf_nco

Overview:
- Numerically controlled oscillator directly downstream of the digital loop filter.
- Consumes the filter's signed frequency-correction samples on an AXI-stream slave and adds them, scaled, to a programmable base frequency control word (FCW).
- Advances a phase accumulator once per accepted output beat and streams truncated phase words on an AXI-stream master to the phase detector / phase-to-amplitude stage.

Parameters:
- CTRL_WIDTH, 16, width of the signed correction input (matches the loop-filter output width).
- ACC_WIDTH, 32, width of the phase accumulator and FCW.
- OUT_WIDTH, 16, width of the output phase word; must be <= ACC_WIDTH.
- GAIN_SHIFT, 8, left shift applied to the sign-extended correction; must satisfy GAIN_SHIFT + CTRL_WIDTH <= ACC_WIDTH.

Ports:
- aclk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  CTRL_WIDTH  signed frequency correction (two's complement).
- s_axis_tlast  in  1  phase-sync request, qualified by s_axis_tvalid.
- s_axis_tvalid  in  1  correction valid.
- s_axis_tready  out  1  correction accepted.
- m_axis_tdata  out  OUT_WIDTH  phase word, equal to acc[ACC_WIDTH-1 -: OUT_WIDTH].
- m_axis_tlast  out  1  set when the accumulation producing this beat carried out of bit ACC_WIDTH-1.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- base_fcw  in  ACC_WIDTH  unsigned nominal frequency word; quasi-static.
- enable  in  1  run request.
- fcw_out  out  ACC_WIDTH  currently applied FCW (status).
- wrap_count  out  16  count of emitted beats with m_axis_tlast = 1; wraps at 2^16.

Behaviour:
- Reset (resetn = 0 at a rising edge) forces:
  - acc = 0, corr_reg = 0, fcw_reg = 0, sync_pend = 0.
  - m_axis_tdata = 0, m_axis_tlast = 0, m_axis_tvalid = 0, wrap_count = 0, state = IDLE.
  - s_axis_tready = 0 during reset, 1 otherwise.
  - Reset mid-stall drops m_axis_tvalid immediately; this is the only permitted drop of valid without a handshake.
- Correction path:
  - s_axis_tready = 1 whenever out of reset; the latest correction wins.
  - On an s handshake at edge n: corr_reg <= s_axis_tdata.
  - At edge n+1: fcw_reg <= base_fcw + (sign_extend(corr_reg) << GAIN_SHIFT), modulo 2^ACC_WIDTH.
  - The new FCW is first used by the output handshake at edge n+2.
  - fcw_reg is recomputed every cycle, so base_fcw changes also apply after 1 cycle.
  - fcw_out = fcw_reg.
- Phase sync:
  - An s handshake with s_axis_tlast = 1 sets sync_pend.
  - At the next output handshake (strictly after the edge that set sync_pend): acc_next = 0, m_axis_tlast <= 0, sync_pend <= 0.
- State machine (2 states):
  - IDLE: m_axis_tvalid = 0; acc holds. If enable = 1, go to RUN; at that edge m_axis_tvalid <= 1 and m_axis_tdata <= top bits of acc (current phase, no advance).
  - RUN: m_axis_tvalid = 1. On each output handshake (tvalid & tready):
    - acc_next = acc + fcw_reg, ACC_WIDTH-bit wrap.
    - acc <= acc_next.
    - m_axis_tdata <= acc_next[ACC_WIDTH-1 -: OUT_WIDTH].
    - m_axis_tlast <= carry.
    - wrap_count increments when the newly loaded tlast = 1.
  - RUN -> IDLE when enable = 0 and an output handshake occurs; tvalid <= 0 at that edge.
  - While stalled (tvalid & !tready): tdata and tlast are held stable and acc holds. enable = 0 during a stall has no effect until the handshake.
- Simultaneous events:
  - s handshake and output handshake in the same cycle: the output uses the old fcw_reg.
  - sync_pend set and output handshake in the same cycle: the sync applies at the following handshake.
- Throughput: 1 phase word per cycle while m_axis_tready = 1.

Optional Feature:
- Macro: DLF_NCO_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances on each output handshake.
  - Its low (ACC_WIDTH-OUT_WIDTH) bits, zero-extended (capped at 16 bits), are added to acc_next for the output word only; acc itself is undithered.
  - Carry from the dither addition is discarded.
  - m_axis_tlast still reflects the undithered accumulator carry.
- Undefined: no LFSR is present; output is pure truncation.

Test Plan (defaults: ACC_WIDTH 32, OUT_WIDTH 16, GAIN_SHIFT 8):
- Reset, then base_fcw = 0x1000_0000, no s beats, enable = 1, tready = 1 -> tdata 0x0000, 0x1000, ..., 0xF000, then 0x0000 with tlast = 1 on the 16th handshake; wrap_count = 1.
- Send s beat tdata = 0x0100 -> fcw_out = 0x1001_0000 two edges later; the next increment is 0x1001. Send 0xFF00 (-256) -> fcw_out = 0x0FFF_0000.
- During RUN, tready low for 5 cycles -> tdata/tlast stable, acc unchanged; on release the sequence resumes without a skipped phase.
- s beat with tlast = 1 while tready = 1 -> the second following output beat has tdata = 0x0000, tlast = 0; subsequent beats resume stepping from 0.
- enable = 0 while stalled, tready = 0 for 3 cycles, then 1 -> one final handshake, then tvalid = 0. Re-enable -> first beat repeats the last-held phase without advance.
- Assert resetn = 0 mid-stall -> all outputs 0 on the next cycle, wrap_count = 0. With DLF_NCO_DITHER_EN defined, base_fcw = 0x0001_0000 -> tdata increments by exactly 1 per beat (dither < 1 LSB), tlast unchanged.
